// File: rtl/fetch_pkg.sv
// Shared types and constants for the two-byte instruction fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HI_REQ = 2'd1,
    LO_REQ = 2'd2,
    DONE   = 2'd3
  } fetch_state_t;

  localparam int DEFAULT_TIMEOUT_CYCLES = 15;
  localparam int TIMER_W                = 8;

endpackage

// File: rtl/fetch_wait_timer.sv
// ROM wait-cycle counter: held at zero while cleared, counts stalled cycles,
// and flags the last permitted stalled cycle of a byte read.
module fetch_wait_timer
  import fetch_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run) begin
      count <= count + 1'b1;
    end
  end

  assign expired = run && (count == LAST);

endmodule

// File: rtl/instruction_fetch_controller.sv
// Sequences high/low instruction byte reads from wait-state program ROM,
// driving PC increment and IR byte enables, with flush abort and timeout fault.
module instruction_fetch_controller
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH     = 12,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] pc_value,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_rd,
  input  logic                  rom_ack,
  output logic                  pc_inc,
  output logic                  ir_high_write_enable,
  output logic                  ir_low_write_enable,
  output logic                  fetch_done,
  output logic                  busy,
  output logic                  fetch_fault
);

  fetch_state_t state;
  logic         fault_q;
  logic         in_req;
  logic         take;
  logic         expired;

  assign in_req   = (state == HI_REQ) || (state == LO_REQ);
  assign rom_addr = pc_value;
  assign rom_rd   = in_req && !flush;
  assign take     = rom_rd && rom_ack;

  // Byte capture is Mealy on rom_ack so the IR and PC move on the ack edge.
  assign pc_inc               = take;
  assign ir_high_write_enable = take && (state == HI_REQ);
  assign ir_low_write_enable  = take && (state == LO_REQ);
  assign fetch_done           = (state == DONE);
  assign busy                 = in_req;
  assign fetch_fault          = fault_q;

  // Clearing on ack (and outside the request states) gives each byte a fresh budget.
  fetch_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (!in_req || rom_ack || flush),
    .run    (in_req && !rom_ack && !flush),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      fault_q <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (fetch_req) begin
            state   <= HI_REQ;
            fault_q <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        HI_REQ: begin
          if (rom_ack) begin
            state <= LO_REQ;
          end else if (expired) begin
            state   <= IDLE;
            fault_q <= 1'b1;
          end
        end
        LO_REQ: begin
          if (rom_ack) begin
            state <= DONE;
          end else if (expired) begin
            state   <= IDLE;
            fault_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
